// File: rtl/bit_scatter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bit_scatter_pkg
//  Description : Shared types and constants for the bit scatter buffer
//                (bank state enum, frame geometry, beat-count width/limit).
//  Revision    : 1.0 - initial release
// ============================================================================
package bit_scatter_pkg;

    localparam int FRAME_W     = 256;
    localparam int FRAME_IDX_W = 8;
    localparam int CNT_W       = 9;
    localparam logic [CNT_W-1:0] CNT_MAX = 9'h1FF;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    // Beat counter increment that sticks at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

endpackage : bit_scatter_pkg
`default_nettype wire

// File: rtl/bit_scatter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : bit_scatter_bank
//  Description : One frame bank: bit vector, saturating beat count, optional
//                written-mask and EMPTY/FILLING/FULL state. A write updates one
//                bit; a write with commit closes the frame; release returns the
//                bank to EMPTY with cleared contents.
//                Optional written-mask built when SCATTER_MASK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_scatter_bank
    import bit_scatter_pkg::*;
#(
    parameter int WIDTH = FRAME_W,
    parameter int IDX_W = FRAME_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic             i_commit,
    input  logic             i_release,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
`ifdef SCATTER_MASK_EN
    output logic [WIDTH-1:0] o_mask,
`endif
    output bank_state_e      o_state
);

    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] count_q, count_d;
    bank_state_e      state_q, state_d;
`ifdef SCATTER_MASK_EN
    logic [WIDTH-1:0] mask_q,  mask_d;
`endif

    // Next-state: release wipes the bank; a write sets one bit and advances state.
    // The top only writes a non-FULL bank and only releases a FULL one, so the
    // two never coincide on the same bank.
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        state_d = state_q;
`ifdef SCATTER_MASK_EN
        mask_d  = mask_q;
`endif
        if (i_release) begin
            data_d  = '0;
            count_d = '0;
            state_d = EMPTY;
`ifdef SCATTER_MASK_EN
            mask_d  = '0;
`endif
        end else if (i_we) begin
            data_d[i_idx] = i_bit;
            count_d       = sat_inc(count_q);
            state_d       = i_commit ? FULL : FILLING;
`ifdef SCATTER_MASK_EN
            mask_d[i_idx] = 1'b1;
`endif
        end
    end

    // Bank registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            count_q <= '0;
            state_q <= EMPTY;
`ifdef SCATTER_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            state_q <= state_d;
`ifdef SCATTER_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign o_data  = data_q;
    assign o_count = count_q;
    assign o_state = state_q;
`ifdef SCATTER_MASK_EN
    assign o_mask  = mask_q;
`endif

endmodule : bit_scatter_bank
`default_nettype wire

// File: rtl/bit_scatter_buf.sv
`default_nettype none
// ============================================================================
//  Module      : bit_scatter_buf
//  Description : Ping-pong bit scatter buffer. (index, bit) beats are scattered
//                into the fill bank; a completed frame is held on a
//                valid/ready output while the other bank fills.
//                Define SCATTER_MASK_EN to add the written-mask and out_mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_scatter_buf
    import bit_scatter_pkg::*;
#(
    parameter int WIDTH = FRAME_W,     // power of two
    parameter int IDX_W = FRAME_IDX_W  // log2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_bit,
    input  logic             wr_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
`ifdef SCATTER_MASK_EN
    ,
    output logic [WIDTH-1:0] out_mask
`endif
);

    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        w_accept;
    logic        w_xfer;

    logic [WIDTH-1:0] w_data  [2];
    logic [CNT_W-1:0] w_count [2];
    bank_state_e      w_state [2];
`ifdef SCATTER_MASK_EN
    logic [WIDTH-1:0] w_mask  [2];
`endif

    // Handshake decode from registered bank state only; out_ready never
    // reaches wr_ready, so a freed bank costs one bubble cycle.
    always_comb begin
        wr_ready  = (w_state[wr_ptr_q] != FULL);
        out_valid = (w_state[rd_ptr_q] == FULL);
        w_accept  = wr_valid && wr_ready;
        w_xfer    = out_valid && out_ready;
    end

    // Pointer advance: fill side on commit, output side on transfer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_accept && wr_last) wr_ptr_d = ~wr_ptr_q;
        if (w_xfer)              rd_ptr_d = ~rd_ptr_q;
    end

    // Bank pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic w_sel_wr;
        logic w_sel_rd;
        assign w_sel_wr = (int'(wr_ptr_q) == b);
        assign w_sel_rd = (int'(rd_ptr_q) == b);

        bit_scatter_bank #(
            .WIDTH (WIDTH),
            .IDX_W (IDX_W)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .i_we      (w_accept && w_sel_wr),
            .i_commit  (wr_last),
            .i_release (w_xfer && w_sel_rd),
            .i_idx     (wr_idx),
            .i_bit     (wr_bit),
            .o_data    (w_data[b]),
            .o_count   (w_count[b]),
`ifdef SCATTER_MASK_EN
            .o_mask    (w_mask[b]),
`endif
            .o_state   (w_state[b])
        );
    end

    // Output mux: the bank addressed by rd_ptr is presented; both sources are
    // registers, so the outputs hold steady under backpressure.
    always_comb begin
        out_data  = w_data[rd_ptr_q];
        out_count = w_count[rd_ptr_q];
`ifdef SCATTER_MASK_EN
        out_mask  = w_mask[rd_ptr_q];
`endif
    end

endmodule : bit_scatter_buf
`default_nettype wire

// File: tb/tb_bit_scatter_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_scatter_buf
//  Description : Self-checking bench for bit_scatter_buf: directed scenarios
//                with literal expectations plus randomized traffic compared
//                each cycle against a frame-queue reference model.
//                Honors SCATTER_MASK_EN for the out_mask port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_scatter_buf;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [7:0]   wr_idx = 8'd0;
    logic         wr_bit = 1'b0;
    logic         wr_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] out_data;
    logic [8:0]   out_count;
`ifdef SCATTER_MASK_EN
    logic [255:0] out_mask;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_scatter_buf dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_idx    (wr_idx),
        .wr_bit    (wr_bit),
        .wr_last   (wr_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
`ifdef SCATTER_MASK_EN
        ,
        .out_mask  (out_mask)
`endif
    );

    // ------------------------------------------------------------------
    // Reference model: a frame under construction plus a queue of completed
    // frames. Two banks means at most two completed frames can be held.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [255:0] d;
        logic [255:0] m;
        logic [8:0]   c;
    } frame_t;

    frame_t       done_q[$];
    logic [255:0] f_d = '0;
    logic [255:0] f_m = '0;
    logic [8:0]   f_c = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q.delete();
            f_d = '0;
            f_m = '0;
            f_c = '0;
        end else begin
            logic   acc;
            logic   xfer;
            frame_t fr;
            acc  = wr_valid && (done_q.size() < 2);
            xfer = (done_q.size() > 0) && out_ready;
            if (xfer) void'(done_q.pop_front());
            if (acc) begin
                f_d[wr_idx] = wr_bit;
                f_m[wr_idx] = 1'b1;
                f_c = (f_c == 9'd511) ? f_c : f_c + 9'd1;
                if (wr_last) begin
                    fr.d = f_d;
                    fr.m = f_m;
                    fr.c = f_c;
                    done_q.push_back(fr);
                    f_d = '0;
                    f_m = '0;
                    f_c = '0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        chk("wr_ready", 256'(wr_ready), 256'(done_q.size() < 2));
        chk("out_valid", 256'(out_valid), 256'(done_q.size() > 0));
        if (done_q.size() > 0) begin
            chk("out_data", out_data, done_q[0].d);
            chk("out_count", 256'(out_count), 256'(done_q[0].c));
`ifdef SCATTER_MASK_EN
            chk("out_mask", out_mask, done_q[0].m);
`endif
        end
    end

    // Drive one cycle of inputs just after a falling edge; return at the next
    // falling edge, where the post-edge state can be inspected.
    task automatic cyc(input logic v, input logic [7:0] idx, input logic b,
                       input logic l, input logic ordy);
        wr_valid  = v;
        wr_idx    = idx;
        wr_bit    = b;
        wr_last   = l;
        out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [255:0] exp_v;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_ready", 256'(wr_ready), 256'(1));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_data", out_data, 256'(0));
        chk("rst_out_count", 256'(out_count), 256'(0));
`ifdef SCATTER_MASK_EN
        chk("rst_out_mask", out_mask, 256'(0));
`endif
        rst = 1'b0;
        @(negedge clk);

        // Basic frame: bits 0, 255, 128
        cyc(1'b1, 8'd0,   1'b1, 1'b0, 1'b1);
        cyc(1'b1, 8'd255, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 8'd128, 1'b1, 1'b1, 1'b1);
        exp_v = '0;
        exp_v[0] = 1'b1; exp_v[128] = 1'b1; exp_v[255] = 1'b1;
        chk("basic_valid", 256'(out_valid), 256'(1));
        chk("basic_data", out_data, exp_v);
        chk("basic_count", 256'(out_count), 256'(3));
`ifdef SCATTER_MASK_EN
        chk("basic_mask", out_mask, exp_v);
`endif
        drain();

        // Overwrite: last write to idx 5 wins
        cyc(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
        chk("ovw_valid", 256'(out_valid), 256'(1));
        chk("ovw_data", out_data, 256'(0));
        chk("ovw_count", 256'(out_count), 256'(2));
`ifdef SCATTER_MASK_EN
        chk("ovw_mask", out_mask, 256'h20);
`endif
        drain();

        // Backpressure: two single-beat frames fill both banks
        cyc(1'b1, 8'd1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'd2, 1'b1, 1'b1, 1'b0);
        chk("bp_wr_ready", 256'(wr_ready), 256'(0));
        chk("bp_data_first", out_data, 256'h2);
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("bp_valid_next", 256'(out_valid), 256'(1));
        chk("bp_data_next", out_data, 256'h4);
        chk("bp_wr_ready_back", 256'(wr_ready), 256'(1));
        drain();

        // Count saturation: 600 beats to idx 7
        for (int i = 0; i < 600; i++)
            cyc(1'b1, 8'd7, 1'b1, (i == 599), 1'b0);
        chk("sat_count", 256'(out_count), 256'(511));
        chk("sat_data", out_data, 256'h80);
        drain();

        // Simultaneous commit of B and release of A
        cyc(1'b1, 8'd9,  1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'd10, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'd11, 1'b1, 1'b1, 1'b1);
        chk("sim_valid", 256'(out_valid), 256'(1));
        chk("sim_data", out_data, 256'hC00);
        chk("sim_count", 256'(out_count), 256'(2));
        drain();

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 8'(i + 20), 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("mrst_valid", 256'(out_valid), 256'(0));
        chk("mrst_data", out_data, 256'(0));
        rst = 1'b0;
        cyc(1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
        chk("mrst_frame_data", out_data, 256'h8);
        chk("mrst_frame_count", 256'(out_count), 256'(1));
        drain();

        // Randomized traffic, light then heavy backpressure
        for (int i = 0; i < 1500; i++) begin
            logic ordy;
            if (i < 750) ordy = ($urandom_range(0, 3) != 0);
            else         ordy = ($urandom_range(0, 3) == 0);
            cyc(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                ($urandom_range(0, 7) == 0), ordy);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bit_scatter_buf
`default_nettype wire
